ampel_controller: RTL
=====================

# ampel_controller

Clocked, parametrised traffic-light controller for an intersection with `N_DIR` approach directions. It sequences red/red-yellow/green/yellow phases with programmable durations and demand-driven round-robin service. It also supports an all-red clearance interval and a night mode with flashing yellow. Per-direction colour codes are the team's standard 2-bit lamp encoding: 00 green, 01 yellow, 10 red, 11 red & yellow.

## Interface
- `N_DIR`, 2, number of directions; legal range 2..8.
- `CNT_W`, 8, width of the phase down-counter.
- `T_GREEN`, 20, minimum green duration in cycles.
- `T_YELLOW`, 3, yellow duration in cycles.
- `T_RED_YELLOW`, 2, red-yellow duration in cycles.
- `T_ALL_RED`, 2, all-red clearance duration in cycles.
- `T_BLINK`, 10, night-mode half blink period in cycles.
- All `T_*` parameters must lie in 1..2^CNT_W.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `anforderung`  in  N_DIR  per-direction demand (detector/button); level-sampled every cycle.
- `nacht`  in  1  night-mode request.
- `ampelfarbe`  out  2*N_DIR  colour of direction i at bits [2i+1:2i].
- `blank`  out  1  1 = all lamps dark (night blink off-phase).
- `gruen_idx`  out  clog2(N_DIR)  index of the direction currently served (RED_YELLOW/GREEN/YELLOW).

## Operation
- FSM states: ALL_RED, RED_YELLOW, GREEN, YELLOW, NIGHT.
- Phase timer: loaded with T_x−1 on entry to a state; the state ends in the cycle where timer==0. Every timed state lasts exactly T_x cycles.
- Lamp decode per state:
  - ALL_RED: all 10.
  - RED_YELLOW: served direction 11, others 10.
  - GREEN: served 00, others 10.
  - YELLOW: served 01, others 10.
  - NIGHT: all 01.
- `blank` is 0 in every state except NIGHT.
- Demand latch `pending[N_DIR]`:
  - `pending[j]` is set when `anforderung[j]`=1.
  - It is cleared on entry to RED_YELLOW for j.
  - Demand for the served direction is ignored from RED_YELLOW through YELLOW.
- GREEN exit. After the T_GREEN minimum, leave to YELLOW in the first cycle with either:
  - `nacht`=1, or
  - some j≠served with `pending[j]` or `anforderung[j]` set (same-cycle demand counts).
- Otherwise GREEN is extended indefinitely.
- Next direction is computed at GREEN exit and stored in `next_dir`: the first j in served+1, served+2, … (mod N_DIR) with demand. If none, served+1 mod N_DIR.
- YELLOW always proceeds to ALL_RED.
- ALL_RED exit:
  - If `nacht`=1: go to NIGHT.
  - Else if entered from reset or from NIGHT: go to RED_YELLOW for direction 0.
  - Else: go to RED_YELLOW for `next_dir`.
- NIGHT:
  - `blank` starts 0 and toggles every T_BLINK cycles.
  - When `nacht`=0 is sampled: go to ALL_RED with `blank`=0. Pending demand is retained.
- `nacht` is never acted on in RED_YELLOW, YELLOW or ALL_RED entry timing. Clearance and yellow are never shortened.

## Timing
- All outputs are registered and change only on `clk` rising edges (or asynchronously on `rst`). There is no combinational path from inputs to outputs.
- Reset (async, any time, including mid-phase):
  - state=ALL_RED, timer=T_ALL_RED−1.
  - `ampelfarbe` all 10, `blank`=0, `gruen_idx`=0.
  - `pending`=0, `next_dir`=0.
- After `rst` release: T_ALL_RED cycles of all-red, then T_RED_YELLOW cycles of dir0=11, then dir0=00.
- Demand latency: a request sampled at cycle c, while direction d is in GREEN past its minimum, produces YELLOW on d from cycle c+1. The requested direction then reaches 00 after T_YELLOW+T_ALL_RED+T_RED_YELLOW more cycles.
- Night entry from GREEN: YELLOW (T_YELLOW), ALL_RED (T_ALL_RED), then NIGHT.
- Night exit: all 10 for T_ALL_RED cycles, then dir0 red-yellow.
- Counter wrap is impossible by parameter range; the timer never underflows (reload on every state entry).

## Test plan
- Reset release, defaults, N_DIR=2, no demand: `ampelfarbe`={10,10} for 2 cycles → {10,11} for 2 → {10,00} held for 100 cycles; `gruen_idx`=0.
- `anforderung`=2'b10 pulsed 1 cycle at green cycle 5 → dir0 stays 00 until cycle 20 → 01 for 3 cycles → {10,10} for 2 → {11,10} for 2 → {00,10}; `gruen_idx`=1; `pending`=0.
- N_DIR=4, dir0 green, demand on dirs 3 and 2 in the same cycle → service order dir2 then dir3 (round-robin); dir3 green follows dir2 green after dir2's T_GREEN.
- `nacht`=1 during dir0 RED_YELLOW → full T_GREEN of 20 still given → yellow 3 → all-red 2 → all 01 with `blank` 0 for 10 cycles, 1 for 10 cycles, repeating. `nacht`=0 → all 10 with `blank`=0 for 2 cycles → dir0 11.
- `rst` asserted mid-YELLOW between clock edges → outputs all 10 immediately, `blank`=0; after release the sequence restarts exactly as in the first scenario.
- T_GREEN=1, T_YELLOW=1, T_RED_YELLOW=1, T_ALL_RED=1, continuous demand on both directions → directions alternate, each phase exactly 1 cycle: 00, 01, all-red, 11 repeating, with no extra cycles.

Source files
------------

// File: rtl/ampel_controller_if.sv
// Lamp-controller bus: demand/night inputs toward the controller and the
// registered lamp outputs back.
interface ampel_controller_if #(
  parameter int N_DIR = 2
);
  localparam int IDX_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;

  logic [N_DIR-1:0]   anforderung;
  logic               nacht;
  logic [2*N_DIR-1:0] ampelfarbe;
  logic               blank;
  logic [IDX_W-1:0]   gruen_idx;

  modport master (output anforderung, nacht, input ampelfarbe, blank, gruen_idx);
  modport slave  (input anforderung, nacht, output ampelfarbe, blank, gruen_idx);
endinterface

// File: rtl/ampel_controller.sv
// Traffic-light controller: round-robin demand service over N_DIR approaches,
// all-red clearance between services and a flashing-yellow night mode.
module ampel_controller #(
  parameter int N_DIR        = 2,
  parameter int CNT_W        = 8,
  parameter int T_GREEN      = 20,
  parameter int T_YELLOW     = 3,
  parameter int T_RED_YELLOW = 2,
  parameter int T_ALL_RED    = 2,
  parameter int T_BLINK      = 10
) (
  input  logic               clk,
  input  logic               rst,
  ampel_controller_if.slave  bus
);
  localparam int IDX_W = $clog2(N_DIR);

  localparam logic [1:0] C_GREEN      = 2'b00;
  localparam logic [1:0] C_YELLOW     = 2'b01;
  localparam logic [1:0] C_RED        = 2'b10;
  localparam logic [1:0] C_RED_YELLOW = 2'b11;

  localparam logic [CNT_W-1:0] LD_GREEN      = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_RED_YELLOW = CNT_W'(T_RED_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_BLINK      = CNT_W'(T_BLINK - 1);

  typedef enum logic [2:0] {
    ST_ALL_RED, ST_RED_YELLOW, ST_GREEN, ST_YELLOW, ST_NIGHT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [IDX_W-1:0]   served;
  logic [IDX_W-1:0]   next_dir;
  logic [N_DIR-1:0]   pending;
  logic               from_start;
  logic [2*N_DIR-1:0] lamps_q;
  logic               blank_q;

  logic [N_DIR-1:0]   served_mask;
  logic [N_DIR-1:0]   other_dem;
  logic [IDX_W-1:0]   dir_sel;

  function automatic logic [N_DIR-1:0] onehot(input logic [IDX_W-1:0] dir);
    return {{(N_DIR-1){1'b0}}, 1'b1} << dir;
  endfunction

  function automatic logic [2*N_DIR-1:0] lamps(input state_t st, input logic [IDX_W-1:0] dir);
    logic [2*N_DIR-1:0] l;
    for (int i = 0; i < N_DIR; i++) begin
      l[2*i +: 2] = C_RED;
      if (st == ST_NIGHT) l[2*i +: 2] = C_YELLOW;
      else if (IDX_W'(i) == dir) begin
        case (st)
          ST_RED_YELLOW: l[2*i +: 2] = C_RED_YELLOW;
          ST_GREEN:      l[2*i +: 2] = C_GREEN;
          ST_YELLOW:     l[2*i +: 2] = C_YELLOW;
          default:       l[2*i +: 2] = C_RED;
        endcase
      end
    end
    return l;
  endfunction

  // First demanding direction after cur in round-robin order, else cur+1.
  function automatic logic [IDX_W-1:0] pick_next(input logic [N_DIR-1:0] dem,
                                                 input logic [IDX_W-1:0] cur);
    logic [IDX_W-1:0] res;
    logic             found;
    int               idx;
    res   = IDX_W'((int'(cur) + 1) % N_DIR);
    found = 1'b0;
    for (int k = 1; k < N_DIR; k++) begin
      idx = (int'(cur) + k) % N_DIR;
      if (!found && dem[idx]) begin
        res   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    served_mask = onehot(served);
    other_dem   = (pending | bus.anforderung) & ~served_mask;
    dir_sel     = from_start ? '0 : next_dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ALL_RED;
      timer      <= LD_ALL_RED;
      served     <= '0;
      next_dir   <= '0;
      pending    <= '0;
      from_start <= 1'b1;
      lamps_q    <= {N_DIR{C_RED}};
      blank_q    <= 1'b0;
    end else begin
      // The served direction's own detector is ignored while it is being served.
      if (state == ST_RED_YELLOW || state == ST_GREEN || state == ST_YELLOW)
        pending <= pending | (bus.anforderung & ~served_mask);
      else
        pending <= pending | bus.anforderung;

      case (state)
        ST_ALL_RED: begin
          if (timer != '0) timer <= timer - 1'b1;
          else if (bus.nacht) begin
            state   <= ST_NIGHT;
            timer   <= LD_BLINK;
            blank_q <= 1'b0;
            lamps_q <= lamps(ST_NIGHT, served);
          end else begin
            state      <= ST_RED_YELLOW;
            timer      <= LD_RED_YELLOW;
            served     <= dir_sel;
            from_start <= 1'b0;
            pending    <= (pending | bus.anforderung) & ~onehot(dir_sel);
            lamps_q    <= lamps(ST_RED_YELLOW, dir_sel);
          end
        end
        ST_RED_YELLOW: begin
          if (timer != '0) timer <= timer - 1'b1;
          else begin
            state   <= ST_GREEN;
            timer   <= LD_GREEN;
            lamps_q <= lamps(ST_GREEN, served);
          end
        end
        ST_GREEN: begin
          if (timer != '0) timer <= timer - 1'b1;
          else if (bus.nacht || (|other_dem)) begin
            state    <= ST_YELLOW;
            timer    <= LD_YELLOW;
            next_dir <= pick_next(other_dem, served);
            lamps_q  <= lamps(ST_YELLOW, served);
          end
        end
        ST_YELLOW: begin
          if (timer != '0) timer <= timer - 1'b1;
          else begin
            state   <= ST_ALL_RED;
            timer   <= LD_ALL_RED;
            lamps_q <= {N_DIR{C_RED}};
          end
        end
        ST_NIGHT: begin
          if (!bus.nacht) begin
            state      <= ST_ALL_RED;
            timer      <= LD_ALL_RED;
            from_start <= 1'b1;
            blank_q    <= 1'b0;
            lamps_q    <= {N_DIR{C_RED}};
          end else if (timer == '0) begin
            timer   <= LD_BLINK;
            blank_q <= ~blank_q;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state   <= ST_ALL_RED;
          timer   <= LD_ALL_RED;
          lamps_q <= {N_DIR{C_RED}};
        end
      endcase
    end
  end

  assign bus.ampelfarbe = lamps_q;
  assign bus.blank      = blank_q;
  assign bus.gruen_idx  = served;
endmodule
